peripheral_msi_master_port_ahb3: RTL

AHB3-Lite master port of the MSI interconnect: one instance per AHB master, sitting directly upstream of the per-slave arbitrating slave ports. It decodes the master's address against per-slave base/mask pairs and drives a one-hot select towards the slave ports. When the target slave port has not granted this master, it buffers the accepted address phase and stalls the master until the grant arrives. It steers HRDATA/HREADY/HRESP back from the active slave and generates the ERROR response for unmapped accesses.

---
 rtl/peripheral_msi_master_port_ahb3.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/peripheral_msi_master_port_ahb3.sv
// AHB3-Lite master port of the MSI interconnect.
// Decodes the master address against per-slave base/mask pairs and drives a one-hot
// select to the slave ports. When the target slave port has not granted this master,
// the address phase is buffered and the master is stalled until the grant arrives.
// Unmapped accesses receive a two-cycle ERROR response generated locally.
module peripheral_msi_master_port_ahb3 #(
    parameter int unsigned PLEN   = 64,
    parameter int unsigned XLEN   = 64,
    parameter int unsigned SLAVES = 5
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,

    // AHB master request
    input  logic                           mstHSEL,
    input  logic [PLEN-1:0]                mstHADDR,
    input  logic [XLEN-1:0]                mstHWDATA,
    input  logic                           mstHWRITE,
    input  logic [2:0]                     mstHSIZE,
    input  logic [2:0]                     mstHBURST,
    input  logic [3:0]                     mstHPROT,
    input  logic [1:0]                     mstHTRANS,
    input  logic                           mstHMASTLOCK,
    input  logic                           mstHREADY,

    // Response to master
    output logic [XLEN-1:0]                mstHRDATA,
    output logic                           mstHREADYOUT,
    output logic                           mstHRESP,

    // Address map
    input  logic [SLAVES-1:0][PLEN-1:0]    slvHADDRbase,
    input  logic [SLAVES-1:0][PLEN-1:0]    slvHADDRmask,

    // Request towards slave ports
    output logic [SLAVES-1:0]              slvHSEL,
    output logic [PLEN-1:0]                slvHADDR,
    output logic [XLEN-1:0]                slvHWDATA,
    output logic                           slvHWRITE,
    output logic [2:0]                     slvHSIZE,
    output logic [2:0]                     slvHBURST,
    output logic [3:0]                     slvHPROT,
    output logic [1:0]                     slvHTRANS,
    output logic                           slvHMASTLOCK,
    output logic                           slvHREADY,

    // Per-slave response
    input  logic [SLAVES-1:0][XLEN-1:0]    slvHRDATA,
    input  logic [SLAVES-1:0]              slvHREADYOUT,
    input  logic [SLAVES-1:0]              slvHRESP,

    // Arbitration handshake
    input  logic [SLAVES-1:0]              master_granted,
    output logic                           can_switch
);

    localparam int unsigned SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StPending,
        StErr1,
        StErr2
    } state_e;

    // Address phase held back while waiting for the slave port grant
    typedef struct packed {
        logic [PLEN-1:0] addr;
        logic            write;
        logic [2:0]      size;
        logic [2:0]      burst;
        logic [3:0]      prot;
        logic [1:0]      trans;
        logic            lock;
        logic [SW-1:0]   slv;
    } req_buf_t;

    state_e   state_q, state_d;
    logic     [SW-1:0] ds_q, ds_d;
    req_buf_t buf_q, buf_d;

    logic          hit_any;
    logic [SW-1:0] hit_idx;
    logic          hit_granted;
    logic          mst_req;
    logic          xfer;

    // Address decode: lowest-index matching slave wins
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int s = int'(SLAVES) - 1; s >= 0; s--) begin
            if ((mstHADDR & slvHADDRmask[s]) == (slvHADDRbase[s] & slvHADDRmask[s])) begin
                hit_any = 1'b1;
                hit_idx = SW'(s);
            end
        end
    end

    assign hit_granted = master_granted[hit_idx];
    assign mst_req     = mstHSEL & mstHTRANS[1];
    assign xfer        = mst_req & mstHREADY & mstHREADYOUT;

    // State, data-phase slave index and request buffer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            ds_q    <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ds_q    <= ds_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state: route accepted transfers to pass-through, pending buffer or error
    always_comb begin
        state_d = state_q;
        ds_d    = ds_q;
        buf_d   = buf_q;
        case (state_q)
            StIdle, StAccess, StErr2: begin
                if (xfer) begin
                    if (!hit_any) begin
                        state_d = StErr1;
                    end else if (hit_granted) begin
                        state_d = StAccess;
                        ds_d    = hit_idx;
                    end else begin
                        state_d     = StPending;
                        buf_d.addr  = mstHADDR;
                        buf_d.write = mstHWRITE;
                        buf_d.size  = mstHSIZE;
                        buf_d.burst = mstHBURST;
                        buf_d.prot  = mstHPROT;
                        buf_d.trans = mstHTRANS;
                        buf_d.lock  = mstHMASTLOCK;
                        buf_d.slv   = hit_idx;
                    end
                end else if (state_q != StAccess || mstHREADYOUT) begin
                    state_d = StIdle;
                end
            end
            StPending: begin
                // Buffered phase is accepted once the port muxes us and is ready
                if (master_granted[buf_q.slv] && slvHREADYOUT[buf_q.slv]) begin
                    state_d = StAccess;
                    ds_d    = buf_q.slv;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    // Response path back to the master
    always_comb begin
        mstHRDATA    = '0;
        mstHREADYOUT = 1'b1;
        mstHRESP     = 1'b0;
        case (state_q)
            StAccess: begin
                mstHRDATA    = slvHRDATA[ds_q];
                mstHREADYOUT = slvHREADYOUT[ds_q];
                mstHRESP     = slvHRESP[ds_q];
            end
            StPending: mstHREADYOUT = 1'b0;
            StErr1: begin
                mstHREADYOUT = 1'b0;
                mstHRESP     = 1'b1;
            end
            StErr2:  mstHRESP = 1'b1;
            default: ;
        endcase
    end

    // Request path towards the slave ports: buffered phase or live pass-through
    always_comb begin
        slvHSEL      = '0;
        slvHADDR     = mstHADDR;
        slvHWRITE    = mstHWRITE;
        slvHSIZE     = mstHSIZE;
        slvHBURST    = mstHBURST;
        slvHPROT     = mstHPROT;
        slvHTRANS    = HTRANS_IDLE;
        slvHMASTLOCK = mstHMASTLOCK;
        slvHREADY    = mstHREADYOUT;
        if (state_q == StPending) begin
            slvHSEL[buf_q.slv] = 1'b1;
            slvHADDR           = buf_q.addr;
            slvHWRITE          = buf_q.write;
            slvHSIZE           = buf_q.size;
            slvHBURST          = buf_q.burst;
            slvHPROT           = buf_q.prot;
            // The slave port saw no preceding beat from us, so a SEQ must restart as NONSEQ
            slvHTRANS          = (buf_q.trans == HTRANS_SEQ) ? HTRANS_NONSEQ : buf_q.trans;
            slvHMASTLOCK       = buf_q.lock;
            slvHREADY          = 1'b1;
        end else begin
            if (state_q == StAccess) begin
                slvHREADY = mstHREADY;
            end
            if (mst_req && hit_any && hit_granted && state_q != StErr1) begin
                slvHSEL[hit_idx] = 1'b1;
                slvHTRANS        = mstHTRANS;
            end
        end
    end

    assign slvHWDATA = mstHWDATA;

    // A locked sequence or an in-flight burst must keep the slave port's grant
    assign can_switch = ~mstHMASTLOCK &
                        ((state_q != StAccess) |
                         ~((mstHTRANS == HTRANS_SEQ) | (mstHTRANS == HTRANS_BUSY)));

endmodule
